// File: rtl/vga_pkg.sv
// Shared raster timing definitions: standard mode presets and the axis-total helper.
package vga_pkg;

   typedef struct packed {
      logic [15:0] disp;
      logic [15:0] fp;
      logic [15:0] sync;
      logic [15:0] bp;
   } vga_axis_t;

   function automatic int vga_total(input int disp, input int fp, input int sync, input int bp);
      return disp + fp + sync + bp;
   endfunction

   // Industry timings at 60 Hz refresh
   localparam vga_axis_t VGA_640X480_H  = '{16'd640,  16'd16, 16'd96,  16'd48};
   localparam vga_axis_t VGA_640X480_V  = '{16'd480,  16'd10, 16'd2,   16'd33};
   localparam vga_axis_t VGA_800X600_H  = '{16'd800,  16'd40, 16'd128, 16'd88};
   localparam vga_axis_t VGA_800X600_V  = '{16'd600,  16'd1,  16'd4,   16'd23};
   localparam vga_axis_t VGA_1024X768_H = '{16'd1024, 16'd24, 16'd136, 16'd160};
   localparam vga_axis_t VGA_1024X768_V = '{16'd768,  16'd3,  16'd6,   16'd29};

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register with synchronous flush; also exposes bit 0 of the
// stage just before the output so a qualifier can gate data captured beside it.
module vga_delay_line #(
   parameter int W     = 3,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         ce_i,
   input  logic         flush_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         pre_o
);

   logic [DEPTH-1:0][W-1:0] pipe_q;
   logic [DEPTH:0][W-1:0]   stg;

   // stg[j] is the input as it was j ticks ago; stg[0] is live
   assign stg    = {pipe_q, din_i};
   assign dout_o = stg[DEPTH];
   assign pre_o  = stg[DEPTH-1][0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     pipe_q <= '0;
      else if (flush_i) pipe_q <= '0;
      else if (ce_i)    pipe_q <= stg[DEPTH-1:0];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters, strobes, frame counter and a
// latency-matched sync/de/colour output stage for a pipelined pixel source.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_DISPLAY = 800,
   parameter int H_FP      = 40,
   parameter int H_SYNC    = 128,
   parameter int H_BP      = 88,
   parameter int V_DISPLAY = 600,
   parameter int V_FP      = 1,
   parameter int V_SYNC    = 4,
   parameter int V_BP      = 23,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int COLOR_W   = 4,
   parameter int PIPE_LAT  = 0,
   parameter int FC_W      = 16,
   localparam int H_TOTAL  = vga_total(H_DISPLAY, H_FP, H_SYNC, H_BP),
   localparam int V_TOTAL  = vga_total(V_DISPLAY, V_FP, V_SYNC, V_BP),
   localparam int XW       = $clog2(H_TOTAL),
   localparam int YW       = $clog2(V_TOTAL)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               pix_ce,
   input  logic               enable,
   input  logic [COLOR_W-1:0] in_r,
   input  logic [COLOR_W-1:0] in_g,
   input  logic [COLOR_W-1:0] in_b,
   output logic [XW-1:0]      pixel_x,
   output logic [YW-1:0]      pixel_y,
   output logic               req_active,
   output logic               line_start,
   output logic               frame_start,
   output logic [FC_W-1:0]    frame_count,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [COLOR_W-1:0] red,
   output logic [COLOR_W-1:0] green,
   output logic [COLOR_W-1:0] blue
);

   localparam int   HS_BEG = H_DISPLAY + H_FP;
   localparam int   HS_END = HS_BEG + H_SYNC;
   localparam int   VS_BEG = V_DISPLAY + V_FP;
   localparam int   VS_END = VS_BEG + V_SYNC;
   localparam logic HPOL   = 1'(HSYNC_POL);
   localparam logic VPOL   = 1'(VSYNC_POL);

   logic [XW-1:0]   h_q, h_d;
   logic [YW-1:0]   v_q, v_d;
   logic [FC_W-1:0] fc_q, fc_d;
   logic            h_last, v_last, tick;
   logic            hs0, vs0;
   logic [2:0]      sync_q;
   logic            de_tap;
   logic [COLOR_W-1:0] r_q, g_q, b_q;

   assign h_last = (h_q == XW'(H_TOTAL - 1));
   assign v_last = (v_q == YW'(V_TOTAL - 1));
   assign tick   = enable & reset_n & pix_ce;

   always_comb begin
      h_d  = h_q;
      v_d  = v_q;
      fc_d = fc_q;
      if (!enable) begin
         h_d = '0;
         v_d = '0;
      end else if (pix_ce) begin
         h_d = h_last ? '0 : h_q + 1'b1;
         if (h_last) begin
            v_d = v_last ? '0 : v_q + 1'b1;
            if (v_last) fc_d = fc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_q  <= '0;
         v_q  <= '0;
         fc_q <= '0;
      end else begin
         h_q  <= h_d;
         v_q  <= v_d;
         fc_q <= fc_d;
      end
   end

   assign pixel_x     = h_q;
   assign pixel_y     = v_q;
   assign frame_count = fc_q;
   assign req_active  = (32'(h_q) < H_DISPLAY) && (32'(v_q) < V_DISPLAY);
   assign line_start  = tick && (h_q == '0) && (32'(v_q) < V_DISPLAY);
   assign frame_start = tick && (h_q == '0) && (v_q == '0);

   assign hs0 = (32'(h_q) >= HS_BEG) && (32'(h_q) < HS_END);
   assign vs0 = (32'(v_q) >= VS_BEG) && (32'(v_q) < VS_END);

   // Last stage doubles as the pin register; de_tap lines up with the source's colour
   vga_delay_line #(.W(3), .DEPTH(PIPE_LAT + 1)) u_dly (
      .clk     (clk),
      .reset_n (reset_n),
      .ce_i    (pix_ce),
      .flush_i (~enable),
      .din_i   ({hs0, vs0, req_active}),
      .dout_o  (sync_q),
      .pre_o   (de_tap)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q <= '0;
         g_q <= '0;
         b_q <= '0;
      end else if (!enable) begin
         r_q <= '0;
         g_q <= '0;
         b_q <= '0;
      end else if (pix_ce) begin
         r_q <= de_tap ? in_r : '0;
         g_q <= de_tap ? in_g : '0;
         b_q <= de_tap ? in_b : '0;
      end
   end

   assign hsync = ~(sync_q[2] ^ HPOL);
   assign vsync = ~(sync_q[1] ^ VPOL);
   assign de    = sync_q[0];
   assign red   = r_q;
   assign green = g_q;
   assign blue  = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Random-stimulus bench: two instances (zero and 3-tick source latency, both sync
// polarities, 16- and 2-bit frame counters) against an arithmetic raster model.
module tb_vga_timing_gen;

   localparam int HD = 8, HFP = 2, HSW = 2, HBP = 4;
   localparam int VD = 4, VFP = 1, VSW = 1, VBP = 2;
   localparam int HT = HD + HFP + HSW + HBP;
   localparam int VT = VD + VFP + VSW + VBP;
   localparam int FT = HT * VT;
   localparam int LAT1 = 3;

   logic clk = 1'b0;
   logic reset_n, pix_ce, enable;
   logic [3:0]  in_r0, in_g0, in_b0, in_r1, in_g1, in_b1;
   logic [3:0]  pixel_x0, pixel_x1;
   logic [2:0]  pixel_y0, pixel_y1;
   logic        req_active0, req_active1, line_start0, line_start1;
   logic        frame_start0, frame_start1;
   logic [15:0] frame_count0;
   logic [1:0]  frame_count1;
   logic        hsync0, vsync0, de0, hsync1, vsync1, de1;
   logic [3:0]  red0, green0, blue0, red1, green1, blue1;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HSYNC_POL(0), .VSYNC_POL(0), .COLOR_W(4), .PIPE_LAT(0), .FC_W(16)
   ) u_dut0 (
      .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .enable(enable),
      .in_r(in_r0), .in_g(in_g0), .in_b(in_b0),
      .pixel_x(pixel_x0), .pixel_y(pixel_y0), .req_active(req_active0),
      .line_start(line_start0), .frame_start(frame_start0), .frame_count(frame_count0),
      .hsync(hsync0), .vsync(vsync0), .de(de0),
      .red(red0), .green(green0), .blue(blue0)
   );

   vga_timing_gen #(
      .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HSYNC_POL(1), .VSYNC_POL(1), .COLOR_W(4), .PIPE_LAT(LAT1), .FC_W(2)
   ) u_dut1 (
      .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .enable(enable),
      .in_r(in_r1), .in_g(in_g1), .in_b(in_b1),
      .pixel_x(pixel_x1), .pixel_y(pixel_y1), .req_active(req_active1),
      .line_start(line_start1), .frame_start(frame_start1), .frame_count(frame_count1),
      .hsync(hsync1), .vsync(vsync1), .de(de1),
      .red(red1), .green(green1), .blue(blue1)
   );

   int n_vec = 0, n_err = 0;
   // t = pix_ce ticks since the scan last restarted at (0,0); fc = completed frames
   int t = 0, fc = 0;
   logic [11:0] ctab [0:FT-1];

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, got, exp, t, $time);
      end
   endtask

   function automatic int fx(input int k); return k % HT; endfunction
   function automatic int fy(input int k); return (k / HT) % VT; endfunction
   function automatic int cidx(input int k); return fy(k) * HT + fx(k); endfunction

   // Pins after the latest tick show the coordinate issued lat ticks before it
   function automatic logic [14:0] exp_pins(input int lat, input bit pol);
      int k, x, y;
      bit hs, vs, d;
      logic [11:0] c;
      k = t - 1 - lat;
      hs = 0; vs = 0; d = 0; c = '0;
      if (k >= 0) begin
         x  = fx(k);
         y  = fy(k);
         hs = (x >= HD + HFP) && (x < HD + HFP + HSW);
         vs = (y >= VD + VFP) && (y < VD + VFP + VSW);
         d  = (x < HD) && (y < VD);
         if (d) c = ctab[cidx(k)];
      end
      return {(hs ? pol : ~pol), (vs ? pol : ~pol), d, c};
   endfunction

   task automatic check_regs();
      logic [14:0] e0, e1;
      int x, y;
      x = fx(t); y = fy(t);
      e0 = exp_pins(0, 1'b0);
      e1 = exp_pins(LAT1, 1'b1);
      chk("pixel_x0", pixel_x0, x);
      chk("pixel_y0", pixel_y0, y);
      chk("req_active0", req_active0, int'(x < HD && y < VD));
      chk("pixel_x1", pixel_x1, x);
      chk("pixel_y1", pixel_y1, y);
      chk("req_active1", req_active1, int'(x < HD && y < VD));
      chk("frame_count0", frame_count0, fc % 65536);
      chk("frame_count1", frame_count1, fc % 4);
      chk("hsync0", hsync0, e0[14]);
      chk("vsync0", vsync0, e0[13]);
      chk("de0", de0, e0[12]);
      chk("rgb0", {red0, green0, blue0}, e0[11:0]);
      chk("hsync1", hsync1, e1[14]);
      chk("vsync1", vsync1, e1[13]);
      chk("de1", de1, e1[12]);
      chk("rgb1", {red1, green1, blue1}, e1[11:0]);
   endtask

   task automatic cyc(input bit ce, input bit en);
      bit ls, fs;
      @(negedge clk);
      pix_ce = ce;
      enable = en;
      {in_r0, in_g0, in_b0} = (ce && en) ? ctab[cidx(t)] : 12'($urandom);
      {in_r1, in_g1, in_b1} = (ce && en && t >= LAT1) ? ctab[cidx(t - LAT1)] : 12'($urandom);
      #1;
      ls = en && ce && fx(t) == 0 && fy(t) < VD;
      fs = en && ce && fx(t) == 0 && fy(t) == 0;
      chk("line_start0", line_start0, ls);
      chk("frame_start0", frame_start0, fs);
      chk("line_start1", line_start1, ls);
      chk("frame_start1", frame_start1, fs);
      @(posedge clk);
      if (!en) t = 0;
      else if (ce) begin
         if (t % FT == FT - 1) fc++;
         t++;
      end
      #1 check_regs();
   endtask

   // Asynchronous assertion between edges; outputs must collapse immediately
   task automatic rst_pulse();
      #2 reset_n = 1'b0;
      t = 0;
      fc = 0;
      #1 check_regs();
      @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < FT; i++) ctab[i] = 12'($urandom);
      reset_n = 1'b0;
      enable  = 1'b1;
      pix_ce  = 1'b0;
      {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1} = '0;
      #3 check_regs();
      @(posedge clk);
      #2 reset_n = 1'b1;

      // continuous scan, then half-rate enable
      for (int i = 0; i < 2 * FT + 20; i++) cyc(1'b1, 1'b1);
      for (int i = 0; i < 300; i++) cyc(i % 2 == 0, 1'b1);

      // drop enable with the counter at h=5, v=2, then resume
      for (int i = 0; i < 2 * FT && !(fx(t) == 5 && fy(t) == 2); i++) cyc(1'b1, 1'b1);
      chk("seek_h5v2", int'(fx(t) == 5 && fy(t) == 2), 1);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);

      // reset mid-line
      for (int i = 0; i < 37; i++) cyc(1'b1, 1'b1);
      rst_pulse();
      for (int i = 0; i < 5 * FT + 10; i++) cyc(1'b1, 1'b1);

      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 49) != 0);
         if ($urandom_range(0, 399) == 0) rst_pulse();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
